// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive packet controller: SYNC detect, LSB-first byte assembly,
// EOP detect and bit-stuff / alignment / babble error reporting.
module usb_rx_ctrl #(
  parameter int unsigned SYNC_ZEROS = 6,
  parameter int unsigned MAX_BYTES  = 1027
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_trans,
  input  logic       d,
  input  logic       strobe,
  input  logic       se0,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_error,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {StIdle, StData, StEopWait, StErrWait} state_e;

  localparam logic [1:0] ErrNone   = 2'd0;
  localparam logic [1:0] ErrStuff  = 2'd1;
  localparam logic [1:0] ErrAlign  = 2'd2;
  localparam logic [1:0] ErrBabble = 2'd3;

  state_e      state_q, state_d;
  logic [3:0]  zero_cnt_q, zero_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_active_q, rx_active_d;
  logic        rx_sop_q, rx_sop_d;
  logic        rx_eop_q, rx_eop_d;
  logic        rx_error_q, rx_error_d;
  logic [1:0]  err_code_q, err_code_d;

  logic       bit_evt;
  logic       stuff_err;
  logic [7:0] byte_next;
  logic       sync_ok;
  logic       babble;

  assign bit_evt   = clk_trans & strobe;
  // A dropped stuff bit that reads as 1 means the sender produced seven 1s in a row.
  assign stuff_err = clk_trans & ~strobe & d;
  assign byte_next = {d, shift_q[7:1]};
  assign sync_ok   = 32'(zero_cnt_q) >= SYNC_ZEROS;
  assign babble    = 32'(byte_cnt_q) >= MAX_BYTES;

  always_comb begin
    state_d     = state_q;
    zero_cnt_d  = zero_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_active_d = rx_active_q;
    err_code_d  = err_code_q;
    rx_valid_d  = 1'b0;
    rx_sop_d    = 1'b0;
    rx_eop_d    = 1'b0;
    rx_error_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bit_evt) begin
          if (!d) begin
            if (zero_cnt_q != 4'hF) zero_cnt_d = zero_cnt_q + 4'd1;
          end else begin
            zero_cnt_d = 4'd0;
            if (sync_ok) begin
              rx_sop_d    = 1'b1;
              rx_active_d = 1'b1;
              bit_cnt_d   = 3'd0;
              byte_cnt_d  = 11'd0;
              err_code_d  = ErrNone;
              state_d     = StData;
            end
          end
        end
      end

      StData: begin
        if (stuff_err) begin
          rx_error_d = 1'b1;
          err_code_d = ErrStuff;
          state_d    = StErrWait;
        end else if (se0) begin
          // Any bit event in this cycle is deliberately ignored.
          if (bit_cnt_q == 3'd0) begin
            rx_eop_d = 1'b1;
          end else begin
            rx_error_d = 1'b1;
            err_code_d = ErrAlign;
          end
          state_d = StEopWait;
        end else if (bit_evt) begin
          shift_d   = byte_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (babble) begin
              rx_error_d = 1'b1;
              err_code_d = ErrBabble;
              state_d    = StErrWait;
            end else begin
              rx_data_d  = byte_next;
              rx_valid_d = 1'b1;
              if (byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
            end
          end
        end
      end

      StEopWait, StErrWait: begin
        if (!se0) begin
          state_d     = StIdle;
          rx_active_d = 1'b0;
          zero_cnt_d  = 4'd0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      zero_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 11'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_sop_q    <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_error_q  <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      zero_cnt_q  <= zero_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_active_q <= rx_active_d;
      rx_sop_q    <= rx_sop_d;
      rx_eop_q    <= rx_eop_d;
      rx_error_q  <= rx_error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_active = rx_active_q;
  assign rx_sop    = rx_sop_q;
  assign rx_eop    = rx_eop_q;
  assign rx_error  = rx_error_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Scoreboard bench for usb_rx_ctrl: stimulus pushes expected events, a negedge
// monitor pops and compares each sop/valid/eop/error pulse.
module tb_usb_rx_ctrl;

  logic       clk, rst_n, clk_trans, d, strobe, se0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_sop, rx_eop, rx_error;
  logic [1:0] err_code;

  usb_rx_ctrl #(
    .SYNC_ZEROS(6),
    .MAX_BYTES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_trans(clk_trans),
    .d        (d),
    .strobe   (strobe),
    .se0      (se0),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_active(rx_active),
    .rx_sop   (rx_sop),
    .rx_eop   (rx_eop),
    .rx_error (rx_error),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event kinds as {sop, valid, eop, error}
  localparam logic [3:0] KSop   = 4'b1000;
  localparam logic [3:0] KValid = 4'b0100;
  localparam logic [3:0] KEop   = 4'b0010;
  localparam logic [3:0] KErr   = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [3:0] pulses;
    exp_t       e;
    pulses = {rx_sop, rx_valid, rx_eop, rx_error};
    if (rst_n && pulses != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(pulses), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(pulses), 32'(e.kind));
        if (e.kind == KValid) check("rx_data", 32'(rx_data), 32'(e.data));
        else                  check("err_code", 32'(err_code), 32'(e.data));
      end
    end
  end

  task automatic expect_ev(input logic [3:0] k, input logic [7:0] v);
    exp_t e;
    e.kind = k;
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    clk_trans = 1'b1;
    d         = b;
    strobe    = s;
    cyc(1);
    clk_trans = 1'b0;
    d         = 1'b0;
    strobe    = 1'b0;
    cyc(gap);
  endtask

  task automatic send_sync(input int zeros, input bit exp_sop);
    for (int i = 0; i < zeros; i++) send_bit(1'b0, 1'b1);
    if (exp_sop) expect_ev(KSop, 8'h00);
    send_bit(1'b1, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_valid);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && exp_valid) expect_ev(KValid, b);
      send_bit(b[i], 1'b1);
    end
  endtask

  task automatic send_se0(input int bits);
    se0 = 1'b1;
    cyc(bits * (gap + 1));
    se0 = 1'b0;
  endtask

  task automatic drain(input string name);
    cyc(4);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clk_trans = 1'b0;
    d = 1'b0;
    strobe = 1'b0;
    se0 = 1'b0;
    cyc(3);
    check("reset_outputs", 32'({rx_data, rx_valid, rx_active, rx_sop, rx_eop, rx_error, err_code}),
          32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Good packet, back-to-back bit pulses
    gap = 0;
    send_sync(7, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    expect_ev(KEop, 8'h00);
    se0 = 1'b1;
    cyc(2);
    check("active_during_se0", 32'(rx_active), 32'd1);
    se0 = 1'b0;
    cyc(1);
    check("active_after_eop", 32'(rx_active), 32'd0);
    drain("good_queue_empty");

    // Stuffed bit dropped inside 0xFF, spaced bit pulses
    gap = 3;
    send_sync(6, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    expect_ev(KValid, 8'hFF);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_byte(8'h01, 1'b1);
    expect_ev(KEop, 8'h00);
    send_se0(2);
    drain("stuffed_queue_empty");
    check("stuffed_err_code", 32'(err_code), 32'd0);

    // Stuff error
    gap = 1;
    send_sync(8, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
    expect_ev(KErr, 8'd1);
    send_bit(1'b1, 1'b0);
    send_se0(2);
    drain("stufferr_queue_empty");
    check("stufferr_active", 32'(rx_active), 32'd0);
    check("stufferr_code_held", 32'(err_code), 32'd1);

    // Alignment: SE0 after 11 data bits
    gap = 0;
    send_sync(6, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    expect_ev(KErr, 8'd2);
    send_se0(2);
    drain("align_queue_empty");
    check("align_active", 32'(rx_active), 32'd0);

    // Babble: fifth byte exceeds MAX_BYTES=4
    gap = 2;
    send_sync(6, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    expect_ev(KErr, 8'd3);
    send_byte(8'h05, 1'b0);
    send_se0(2);
    drain("babble_queue_empty");

    // Short SYNC: no rx_sop
    gap = 0;
    send_sync(4, 1'b0);
    send_byte(8'h10, 1'b0);
    drain("short_sync_no_event");
    check("short_sync_active", 32'(rx_active), 32'd0);

    // Reset mid-byte, then a fresh packet
    send_sync(6, 1'b1);
    send_byte(8'h33, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    check("active_before_reset", 32'(rx_active), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({rx_data, rx_valid, rx_active, rx_sop, rx_eop, rx_error, err_code}), 32'd0);
    se0 = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);
    check("se0_over_release_idle", 32'(rx_active), 32'd0);
    se0 = 1'b0;
    cyc(2);
    send_sync(6, 1'b1);
    send_byte(8'hC3, 1'b1);
    expect_ev(KEop, 8'h00);
    send_se0(2);
    drain("post_reset_queue_empty");
    check("post_reset_data", 32'(rx_data), 32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
